bist_engine: RTL and testbench

//  Parametrised on-chip BIST engine between chip pins and the CUT. Generalises the fixed
//  35-in/49-out BIST wrapper to any PI/PO width, with programmable pattern count,

---
 rtl/bist_engine.sv | 115 +++++++++++
 tb/tb_bist_engine.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bist_engine.sv
// Built-in self-test engine: an LFSR drives the CUT and a MISR compacts its responses.
// With bistmode low the pins pass straight through to the CUT.
module bist_engine #(
  parameter int unsigned     PI_W       = 35,
  parameter int unsigned     PO_W       = 49,
  parameter int unsigned     N_PATTERNS = 2000,
  parameter int unsigned     LATENCY    = 0,
  parameter logic [PI_W-1:0] LFSR_POLY  = PI_W'(5),
  parameter logic [PO_W-1:0] MISR_POLY  = PO_W'('h201),
  parameter logic [PI_W-1:0] SEED       = PI_W'(1),
  parameter logic [PO_W-1:0] GOLDEN_SIG = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bistmode,
  input  logic [PI_W-1:0] pi,
  output logic [PI_W-1:0] cut_pi,
  input  logic [PO_W-1:0] cut_po,
  output logic [PO_W-1:0] po,
  output logic            bistdone,
  output logic            bistpass,
  output logic [PO_W-1:0] signature
);

  // An all-zero seed would lock the LFSR at zero forever.
  localparam logic [PI_W-1:0] SeedEff = (SEED == '0) ? PI_W'(1) : SEED;
  localparam int unsigned     CntW    = $clog2(N_PATTERNS + LATENCY + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(N_PATTERNS + LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StRun, StCompare, StDone} state_e;

  state_e          state_q;
  logic [PI_W-1:0] lfsr_q, lfsr_next;
  logic [PO_W-1:0] misr_q, misr_next;
  logic [CntW-1:0] cnt_q;
  logic            done_q, pass_q;
  logic            misr_en;

  always_comb begin
    lfsr_next = {lfsr_q[PI_W-2:0], 1'b0} ^ (lfsr_q[PI_W-1] ? LFSR_POLY : '0);
    misr_next = {misr_q[PO_W-2:0], 1'b0} ^ (misr_q[PO_W-1] ? MISR_POLY : '0) ^ cut_po;
  end

  // Responses only become valid once the CUT pipeline has filled.
  if (LATENCY == 0) begin : g_no_lat
    assign misr_en = 1'b1;
  end else begin : g_lat
    assign misr_en = (cnt_q >= CntW'(LATENCY));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      lfsr_q  <= SeedEff;
      misr_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          lfsr_q <= SeedEff;
          misr_q <= '0;
          cnt_q  <= '0;
          done_q <= 1'b0;
          pass_q <= 1'b0;
          if (bistmode) state_q <= StRun;
        end
        StRun: begin
          if (!bistmode) begin
            state_q <= StIdle;
            lfsr_q  <= SeedEff;
            misr_q  <= '0;
            cnt_q   <= '0;
          end else begin
            lfsr_q <= lfsr_next;
            cnt_q  <= cnt_q + 1'b1;
            if (misr_en) misr_q <= misr_next;
            if (cnt_q == LastCnt) state_q <= StCompare;
          end
        end
        StCompare: begin
          if (!bistmode) begin
            state_q <= StIdle;
            lfsr_q  <= SeedEff;
            misr_q  <= '0;
            cnt_q   <= '0;
          end else begin
            pass_q  <= (misr_q == GOLDEN_SIG);
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          if (!bistmode) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            lfsr_q  <= SeedEff;
            misr_q  <= '0;
            cnt_q   <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cut_pi    = (state_q == StIdle) ? pi : lfsr_q;
  assign po        = cut_po;
  assign bistdone  = done_q;
  assign bistpass  = pass_q;
  assign signature = misr_q;

endmodule

// File: tb/tb_bist_engine.sv
// Directed bench for bist_engine: toy 4-bit configurations plus the default 35/49 build.
module tb_bist_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference MISR signature for an identity CUT (wide=0) or the default-build CUT (wide=1).
  function automatic logic [63:0] model_sig(input int piw, input int pow, input logic [63:0] lpoly,
                                            input logic [63:0] mpoly, input logic [63:0] seed,
                                            input int n, input bit wide);
    logic [63:0] l, m, p, lmask, mmask;
    l = seed;
    m = '0;
    lmask = (64'd1 << piw) - 1;
    mmask = (64'd1 << pow) - 1;
    for (int i = 0; i < n; i++) begin
      p = wide ? ((((l & 64'h3fff) << 35) | l) & mmask) : l;
      m = ((m << 1) & mmask) ^ (((m >> (pow - 1)) & 1) != 0 ? mpoly : 64'd0) ^ p;
      l = ((l << 1) & lmask) ^ (((l >> (piw - 1)) & 1) != 0 ? lpoly : 64'd0);
    end
    return m;
  endfunction

  // dut0: toy, identity CUT with a stuck-at-1 injectable on bit 0
  logic       bm0 = 1'b0, fbit = 1'b0;
  logic [3:0] pi0 = '0, cut_pi0, cut_po0, po0, sig0;
  logic       done0, pass0;
  assign cut_po0 = cut_pi0 | {3'b000, fbit};

  bist_engine #(.PI_W(4), .PO_W(4), .N_PATTERNS(5), .LATENCY(0), .LFSR_POLY(4'h3),
                .MISR_POLY(4'h3), .SEED(4'h1), .GOLDEN_SIG(4'h3)) u_dut0 (
    .clk(clk), .rst(rst), .bistmode(bm0), .pi(pi0), .cut_pi(cut_pi0), .cut_po(cut_po0),
    .po(po0), .bistdone(done0), .bistpass(pass0), .signature(sig0));

  // dut1: toy, one-cycle registered CUT
  logic       bm1 = 1'b0;
  logic [3:0] pi1 = '0, cut_pi1, cut_po1 = '0, po1, sig1;
  logic       done1, pass1;
  always @(posedge clk) cut_po1 <= cut_pi1;

  bist_engine #(.PI_W(4), .PO_W(4), .N_PATTERNS(5), .LATENCY(1), .LFSR_POLY(4'h3),
                .MISR_POLY(4'h3), .SEED(4'h1), .GOLDEN_SIG(4'h3)) u_dut1 (
    .clk(clk), .rst(rst), .bistmode(bm1), .pi(pi1), .cut_pi(cut_pi1), .cut_po(cut_po1),
    .po(po1), .bistdone(done1), .bistpass(pass1), .signature(sig1));

  // dut2: full-period toy LFSR
  logic       bm2 = 1'b0;
  logic [3:0] pi2 = '0, cut_pi2, cut_po2, po2, sig2;
  logic       done2, pass2;
  assign cut_po2 = cut_pi2;

  bist_engine #(.PI_W(4), .PO_W(4), .N_PATTERNS(15), .LATENCY(0), .LFSR_POLY(4'h3),
                .MISR_POLY(4'h3), .SEED(4'h1), .GOLDEN_SIG(4'h0)) u_dut2 (
    .clk(clk), .rst(rst), .bistmode(bm2), .pi(pi2), .cut_pi(cut_pi2), .cut_po(cut_po2),
    .po(po2), .bistdone(done2), .bistpass(pass2), .signature(sig2));

  // dut3: default 35-in/49-out build
  logic        bm3 = 1'b0;
  logic [34:0] pi3 = '0, cut_pi3;
  logic [48:0] cut_po3, po3, sig3;
  logic        done3, pass3;
  assign cut_po3 = {cut_pi3[13:0], cut_pi3};

  bist_engine u_dut3 (
    .clk(clk), .rst(rst), .bistmode(bm3), .pi(pi3), .cut_pi(cut_pi3), .cut_po(cut_po3),
    .po(po3), .bistdone(done3), .bistpass(pass3), .signature(sig3));

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  pat [5];
    logic [15:0] seen;
    logic [63:0] exp_sig;
    int          cyc;
    pat = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3};

    tick();
    rst = 1'b0;
    tick();
    check("rst_done", 64'(done0), 64'd0);
    check("rst_pass", 64'(pass0), 64'd0);
    check("rst_sig", 64'(sig0), 64'd0);

    // Test 1: identity CUT
    bm0 = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t1_cut_pi%0d", i), 64'(cut_pi0), 64'(pat[i]));
      check("t1_done_early", 64'(done0), 64'd0);
      tick();
    end
    check("t1_done_compare", 64'(done0), 64'd0);
    tick();
    check("t1_done", 64'(done0), 64'd1);
    check("t1_pass", 64'(pass0), 64'd1);
    check("t1_sig", 64'(sig0), 64'h3);
    tick();
    check("t1_hold_done", 64'(done0), 64'd1);
    check("t1_hold_lfsr", 64'(cut_pi0), 64'h6);
    check("t1_hold_sig", 64'(sig0), 64'h3);

    // Test 2: stuck-at-1 on cut_po[0], then released
    bm0 = 1'b0;
    tick();
    check("t2_idle_done", 64'(done0), 64'd0);
    check("t2_idle_pass", 64'(pass0), 64'd0);
    fbit = 1'b1;
    bm0  = 1'b1;
    repeat (7) tick();
    check("t2_fault_done", 64'(done0), 64'd1);
    check("t2_fault_pass", 64'(pass0), 64'd0);
    check("t2_fault_sig", 64'(sig0), 64'hd);
    bm0  = 1'b0;
    fbit = 1'b0;
    tick();
    bm0 = 1'b1;
    repeat (7) tick();
    check("t2_rerun_pass", 64'(pass0), 64'd1);
    check("t2_rerun_sig", 64'(sig0), 64'h3);

    // Test 4: abort at cnt=2, then rerun
    bm0 = 1'b0;
    tick();
    bm0 = 1'b1;
    repeat (3) tick();
    bm0 = 1'b0;
    tick();
    check("t4_abort_done", 64'(done0), 64'd0);
    check("t4_abort_pass", 64'(pass0), 64'd0);
    pi0 = 4'ha;
    #1;
    check("t4_abort_passthru", 64'(cut_pi0), 64'ha);
    pi0 = 4'h0;
    bm0 = 1'b1;
    tick();
    check("t4_rerun_first", 64'(cut_pi0), 64'h1);
    repeat (6) tick();
    check("t4_rerun_done", 64'(done0), 64'd1);
    check("t4_rerun_pass", 64'(pass0), 64'd1);
    check("t4_rerun_sig", 64'(sig0), 64'h3);

    // Test 5: functional pass-through, then reset while DONE
    bm0 = 1'b0;
    tick();
    for (int v = 0; v < 16; v++) begin
      pi0 = 4'(v);
      #1;
      check($sformatf("t5_cut_pi%0d", v), 64'(cut_pi0), 64'(v));
      check($sformatf("t5_po%0d", v), 64'(po0), 64'(v));
      check("t5_done", 64'(done0), 64'd0);
      tick();
    end
    pi0 = 4'h0;
    bm0 = 1'b1;
    repeat (7) tick();
    check("t5_done_before_rst", 64'(done0), 64'd1);
    rst = 1'b1;
    tick();
    check("t5_rst_done", 64'(done0), 64'd0);
    check("t5_rst_pass", 64'(pass0), 64'd0);
    rst = 1'b0;
    bm0 = 1'b0;
    tick();

    // Test 3: registered CUT, LATENCY=1
    bm1 = 1'b1;
    repeat (7) tick();
    check("t3_done_edge7", 64'(done1), 64'd0);
    tick();
    check("t3_done_edge8", 64'(done1), 64'd1);
    check("t3_pass", 64'(pass1), 64'd1);
    check("t3_sig", 64'(sig1), 64'h3);

    // Test 6a: every nonzero 4-bit value applied exactly once
    seen = '0;
    bm2  = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) begin
      check("t6_nonzero", 64'(cut_pi2 != 4'h0), 64'd1);
      check("t6_unique", 64'(seen[cut_pi2]), 64'd0);
      seen[cut_pi2] = 1'b1;
      tick();
    end
    check("t6_seen_all", 64'(seen), 64'hfffe);
    check("t6_done_compare", 64'(done2), 64'd0);
    tick();
    exp_sig = model_sig(4, 4, 64'h3, 64'h3, 64'h1, 15, 1'b0);
    check("t6_done", 64'(done2), 64'd1);
    check("t6_sig", 64'(sig2), exp_sig);
    check("t6_pass", 64'(pass2), 64'(exp_sig == 64'd0));

    // Test 6b: default build, two back-to-back runs
    exp_sig = model_sig(35, 49, 64'h5, 64'h201, 64'h1, 2000, 1'b1);
    for (int r = 0; r < 2; r++) begin
      bm3 = 1'b1;
      cyc = 0;
      do begin
        tick();
        cyc++;
      end while (!done3 && cyc < 3000);
      check($sformatf("t6_def_latency_run%0d", r), 64'(cyc), 64'd2002);
      check($sformatf("t6_def_sig_run%0d", r), 64'(sig3), exp_sig);
      check($sformatf("t6_def_pass_run%0d", r), 64'(pass3), 64'(exp_sig == 64'd0));
      bm3 = 1'b0;
      tick();
      check($sformatf("t6_def_idle_run%0d", r), 64'(done3), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
